edram_port_master: RTL and testbench

- Initiator for the eDRAM subsystem memory port. It drives rvalid/raddr and wvalid/waddr/wdata/wbe into edram_ss, and consumes rready/rdata/wready from it.
- It converts single 32-bit core-side requests (req/gnt plus response valid) into 128-bit eDRAM line accesses, with lane steering and byte enables.
- It sits between the SoC interconnect slave port and edram_ss, with one outstanding transaction at a time and a ready-timeout abort.

---
 rtl/edram_pkg.sv | 31 +++
 rtl/edram_port_master_if.sv | 44 ++++
 rtl/edram_lane_steer.sv | 20 ++
 rtl/edram_port_master.sv | 146 ++++++++++++++
 tb/tb_edram_port_master.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/edram_pkg.sv
// Shared constants, FSM state encoding and payload types for the eDRAM port master.
package edram_pkg;

    localparam int unsigned EDRAM_WIDTH    = 64;
    localparam int unsigned EDRAM_DEPTH    = 4096;
    localparam int unsigned ARR_INST_WIDTH = 2;
    localparam int unsigned LINE_W         = EDRAM_WIDTH * ARR_INST_WIDTH;
    localparam int unsigned BE_W           = LINE_W / 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LANES          = LINE_W / WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Response error codes reported on core_err
    localparam logic ERR_OK      = 1'b0;
    localparam logic ERR_RANGE   = 1'b1;
    localparam logic ERR_TIMEOUT = 1'b1;

    // One full-line write beat as presented to the eDRAM
    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic [BE_W-1:0]   be;
    } wr_beat_t;

endpackage

// File: rtl/edram_port_master_if.sv
// Core-side request/response and eDRAM-side line port bundled together.
interface edram_port_master_if
    import edram_pkg::*;
#(
    parameter int unsigned ARR_DEPTH_W = 12
) ();

    logic                   core_req;
    logic                   core_gnt;
    logic                   core_we;
    logic [31:0]            core_addr;
    logic [3:0]             core_be;
    logic [WORD_W-1:0]      core_wdata;
    logic                   core_rvalid;
    logic [WORD_W-1:0]      core_rdata;
    logic                   core_err;

    logic                   rvalid;
    logic [ARR_DEPTH_W-1:0] raddr;
    logic                   rready;
    logic [LINE_W-1:0]      rdata;
    logic                   wvalid;
    logic [ARR_DEPTH_W-1:0] waddr;
    logic [LINE_W-1:0]      wdata;
    logic [BE_W-1:0]        wbe;
    logic                   wready;

    // View of the port master itself
    modport master (
        input  core_req, core_we, core_addr, core_be, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_err,
        output rvalid, raddr, wvalid, waddr, wdata, wbe,
        input  rready, rdata, wready
    );

    // View of the surrounding core and eDRAM subsystem
    modport slave (
        output core_req, core_we, core_addr, core_be, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        input  rvalid, raddr, wvalid, waddr, wdata, wbe,
        output rready, rdata, wready
    );

endinterface

// File: rtl/edram_lane_steer.sv
// Maps a 32-bit word onto a 128-bit line: write replication/byte-enable shift and read lane select.
module edram_lane_steer
    import edram_pkg::*;
(
    input  logic [1:0]        wr_lane,
    input  logic [3:0]        be,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        rd_lane,
    input  logic [LINE_W-1:0] rline,
    output wr_beat_t          beat_c,
    output logic [WORD_W-1:0] rword_c
);

    always_comb begin
        beat_c.data = {LANES{wdata}};
        beat_c.be   = BE_W'(be) << {wr_lane, 2'b00};
        rword_c     = rline[{rd_lane, 5'b00000} +: WORD_W];
    end

endmodule

// File: rtl/edram_port_master.sv
// Single-outstanding initiator turning 32-bit core requests into 128-bit eDRAM line accesses.
module edram_port_master
    import edram_pkg::*;
#(
    parameter int unsigned ARR_INST_DEPTH = 1,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                clk,
    input  logic                rst,
    edram_port_master_if.master bus
);

    localparam int unsigned ARR_DEPTH   = EDRAM_DEPTH * ARR_INST_DEPTH;
    localparam int unsigned ARR_DEPTH_W = $clog2(ARR_DEPTH);
    localparam int unsigned LAT_W       = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int unsigned TO_W        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e                 state;
    logic [1:0]             lane_q;
    logic [LAT_W-1:0]       lat_cnt;
    logic [TO_W-1:0]        wait_cnt;

    logic                   accept_c;
    logic                   oor_c;
    logic                   timeout_c;
    logic                   lat_done_c;
    logic [ARR_DEPTH_W-1:0] line_c;
    wr_beat_t               beat_c;
    logic [WORD_W-1:0]      rword_c;

    assign bus.core_gnt = (state == ST_IDLE);
    assign accept_c     = bus.core_req && (state == ST_IDLE);
    assign line_c       = bus.core_addr[ARR_DEPTH_W+3:4];
    assign oor_c        = {4'b0000, bus.core_addr[31:4]} >= ARR_DEPTH;
    // Abort fires in the cycle whose missing ready would bring the wait count up to TIMEOUT
    assign timeout_c    = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) >= TIMEOUT);
    assign lat_done_c   = (32'(lat_cnt) == RD_LAT);

    edram_lane_steer u_steer (
        .wr_lane (bus.core_addr[3:2]),
        .be      (bus.core_be),
        .wdata   (bus.core_wdata),
        .rd_lane (lane_q),
        .rline   (bus.rdata),
        .beat_c  (beat_c),
        .rword_c (rword_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            lane_q          <= '0;
            lat_cnt         <= '0;
            wait_cnt        <= '0;
            bus.core_rvalid <= 1'b0;
            bus.core_rdata  <= '0;
            bus.core_err    <= 1'b0;
            bus.rvalid      <= 1'b0;
            bus.raddr       <= '0;
            bus.wvalid      <= 1'b0;
            bus.waddr       <= '0;
            bus.wdata       <= '0;
            bus.wbe         <= '0;
        end else begin
            bus.core_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        lane_q   <= bus.core_addr[3:2];
                        wait_cnt <= '0;
                        lat_cnt  <= '0;
                        if (oor_c) begin
                            state          <= ST_RESP;
                            bus.core_rdata <= '0;
                            bus.core_err   <= ERR_RANGE;
                        end else if (bus.core_we) begin
                            state      <= ST_WR;
                            bus.wvalid <= 1'b1;
                            bus.waddr  <= line_c;
                            bus.wdata  <= beat_c.data;
                            bus.wbe    <= beat_c.be;
                        end else begin
                            state      <= ST_RD;
                            bus.rvalid <= 1'b1;
                            bus.raddr  <= line_c;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.wready || timeout_c) begin
                        state           <= ST_RESP;
                        bus.wvalid      <= 1'b0;
                        bus.core_rvalid <= 1'b1;
                        bus.core_rdata  <= '0;
                        bus.core_err    <= bus.wready ? ERR_OK : ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_RD: begin
                    if (bus.rready) begin
                        bus.rvalid <= 1'b0;
                        if (RD_LAT == 0) begin
                            state           <= ST_RESP;
                            bus.core_rvalid <= 1'b1;
                            bus.core_rdata  <= rword_c;
                            bus.core_err    <= ERR_OK;
                        end else begin
                            state   <= ST_RD_WAIT;
                            lat_cnt <= LAT_W'(1);
                        end
                    end else if (timeout_c) begin
                        state           <= ST_RESP;
                        bus.rvalid      <= 1'b0;
                        bus.core_rvalid <= 1'b1;
                        bus.core_rdata  <= '0;
                        bus.core_err    <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_done_c) begin
                        state           <= ST_RESP;
                        bus.core_rvalid <= 1'b1;
                        bus.core_rdata  <= rword_c;
                        bus.core_err    <= ERR_OK;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Range errors arrive without a pulse queued, so they spend one cycle raising it
                    if (bus.core_rvalid) begin
                        state <= ST_IDLE;
                    end else begin
                        bus.core_rvalid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edram_port_master.sv
// Directed bench: one instance with RD_LAT=1/TIMEOUT=255, one with RD_LAT=0/TIMEOUT=4.
module tb_edram_port_master;
    import edram_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    edram_port_master_if #(.ARR_DEPTH_W(12)) bus_a ();
    edram_port_master_if #(.ARR_DEPTH_W(12)) bus_b ();

    edram_port_master #(.ARR_INST_DEPTH(1), .RD_LAT(1), .TIMEOUT(255)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    edram_port_master #(.ARR_INST_DEPTH(1), .RD_LAT(0), .TIMEOUT(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        bus_a.core_req = 1'b0; bus_a.core_we = 1'b0; bus_a.core_addr = '0;
        bus_a.core_be  = '0;   bus_a.core_wdata = '0;
        bus_a.rready   = 1'b0; bus_a.wready = 1'b0; bus_a.rdata = '0;
        bus_b.core_req = 1'b0; bus_b.core_we = 1'b0; bus_b.core_addr = '0;
        bus_b.core_be  = '0;   bus_b.core_wdata = '0;
        bus_b.rready   = 1'b0; bus_b.wready = 1'b0;
        bus_b.rdata    = {32'h600D0003, 32'h600D0002, 32'h0B0B0B01, 32'h600D0000};
        tick();
        tick();

        // Reset state
        chk("rst_gnt",    128'(bus_a.core_gnt),    128'd1);
        chk("rst_rvalid", 128'(bus_a.rvalid),      128'd0);
        chk("rst_wvalid", 128'(bus_a.wvalid),      128'd0);
        chk("rst_crv",    128'(bus_a.core_rvalid), 128'd0);
        chk("rst_crdata", 128'(bus_a.core_rdata),  128'd0);
        chk("rst_cerr",   128'(bus_a.core_err),    128'd0);
        chk("rst_raddr",  128'(bus_a.raddr),       128'd0);
        chk("rst_waddr",  128'(bus_a.waddr),       128'd0);
        chk("rst_wdata",  128'(bus_a.wdata),       128'd0);
        chk("rst_wbe",    128'(bus_a.wbe),         128'd0);
        chk("rst_gnt_b",  128'(bus_b.core_gnt),    128'd1);
        rst = 1'b0;
        tick();

        // Write 0x24: line 2, lane 1, ready immediately
        bus_a.core_req = 1'b1; bus_a.core_we = 1'b1; bus_a.core_addr = 32'h24;
        bus_a.core_be = 4'hF; bus_a.core_wdata = 32'hDEADBEEF; bus_a.wready = 1'b1;
        chk("wr_gnt", 128'(bus_a.core_gnt), 128'd1);
        tick();
        bus_a.core_req = 1'b0;
        chk("wr_wvalid", 128'(bus_a.wvalid), 128'd1);
        chk("wr_rvalid", 128'(bus_a.rvalid), 128'd0);
        chk("wr_waddr",  128'(bus_a.waddr),  128'd2);
        chk("wr_wdata",  bus_a.wdata, {4{32'hDEADBEEF}});
        chk("wr_wbe",    128'(bus_a.wbe),    128'h00F0);
        chk("wr_nogntbusy", 128'(bus_a.core_gnt), 128'd0);
        chk("wr_crv_early", 128'(bus_a.core_rvalid), 128'd0);
        tick();
        chk("wr_crv",    128'(bus_a.core_rvalid), 128'd1);
        chk("wr_cerr",   128'(bus_a.core_err),    128'd0);
        chk("wr_crdata", 128'(bus_a.core_rdata),  128'd0);
        chk("wr_wdrop",  128'(bus_a.wvalid),      128'd0);
        chk("wr_resp_nognt", 128'(bus_a.core_gnt), 128'd0);
        tick();
        bus_a.wready = 1'b0;
        chk("wr_crv_pulse", 128'(bus_a.core_rvalid), 128'd0);
        chk("wr_gnt_back",  128'(bus_a.core_gnt),    128'd1);

        // Read 0x38: line 3, lane 2 (addr[3:2]=2), one cycle of read latency
        bus_a.rdata = {32'hCAFEF00D, 32'h12345678, 32'h0BADC0DE, 32'h55AA55AA};
        bus_a.core_req = 1'b1; bus_a.core_we = 1'b0; bus_a.core_addr = 32'h38;
        bus_a.rready = 1'b1;
        tick();
        bus_a.core_req = 1'b0;
        chk("rd_rvalid", 128'(bus_a.rvalid), 128'd1);
        chk("rd_wvalid", 128'(bus_a.wvalid), 128'd0);
        chk("rd_raddr",  128'(bus_a.raddr),  128'd3);
        tick();
        chk("rd_wait_rvalid", 128'(bus_a.rvalid),      128'd0);
        chk("rd_wait_crv",    128'(bus_a.core_rvalid), 128'd0);
        tick();
        chk("rd_crv",    128'(bus_a.core_rvalid), 128'd1);
        chk("rd_crdata", 128'(bus_a.core_rdata),  128'h12345678);
        chk("rd_cerr",   128'(bus_a.core_err),    128'd0);
        tick();
        bus_a.rready = 1'b0;
        chk("rd_gnt_back", 128'(bus_a.core_gnt), 128'd1);

        // Out-of-range read 0x10000: no eDRAM access, error response
        bus_a.core_req = 1'b1; bus_a.core_we = 1'b0; bus_a.core_addr = 32'h10000;
        tick();
        bus_a.core_req = 1'b0;
        chk("oor_norvalid", 128'(bus_a.rvalid),      128'd0);
        chk("oor_crv_early", 128'(bus_a.core_rvalid), 128'd0);
        tick();
        chk("oor_crv",    128'(bus_a.core_rvalid), 128'd1);
        chk("oor_cerr",   128'(bus_a.core_err),    128'd1);
        chk("oor_crdata", 128'(bus_a.core_rdata),  128'd0);
        chk("oor_norvalid2", 128'(bus_a.rvalid),   128'd0);
        tick();
        chk("oor_crv_pulse", 128'(bus_a.core_rvalid), 128'd0);
        chk("oor_gnt_back",  128'(bus_a.core_gnt),    128'd1);

        // Last in-range line with be=0: legal, issued with wbe=0
        bus_a.core_req = 1'b1; bus_a.core_we = 1'b1; bus_a.core_addr = 32'hFFF0;
        bus_a.core_be = 4'h0; bus_a.core_wdata = 32'h00C0FFEE; bus_a.wready = 1'b1;
        tick();
        bus_a.core_req = 1'b0;
        chk("be0_wvalid", 128'(bus_a.wvalid), 128'd1);
        chk("be0_waddr",  128'(bus_a.waddr),  128'hFFF);
        chk("be0_wbe",    128'(bus_a.wbe),    128'd0);
        tick();
        chk("be0_crv",  128'(bus_a.core_rvalid), 128'd1);
        chk("be0_cerr", 128'(bus_a.core_err),    128'd0);
        tick();
        bus_a.wready = 1'b0;

        // Write 0x1C stalled by wready low for 5 cycles; fields must hold for 6
        bus_a.core_req = 1'b1; bus_a.core_we = 1'b1; bus_a.core_addr = 32'h1C;
        bus_a.core_be = 4'h3; bus_a.core_wdata = 32'hA5A50001;
        tick();
        bus_a.core_req = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) bus_a.wready = 1'b1;
            chk("stall_wvalid", 128'(bus_a.wvalid), 128'd1);
            chk("stall_waddr",  128'(bus_a.waddr),  128'd1);
            chk("stall_wbe",    128'(bus_a.wbe),    128'h3000);
            chk("stall_wdata",  bus_a.wdata, {4{32'hA5A50001}});
            chk("stall_crv",    128'(bus_a.core_rvalid), 128'd0);
            tick();
        end
        bus_a.wready = 1'b0;
        chk("stall_crv_done", 128'(bus_a.core_rvalid), 128'd1);
        chk("stall_cerr",     128'(bus_a.core_err),    128'd0);
        chk("stall_wdrop",    128'(bus_a.wvalid),      128'd0);
        tick();

        // RD_LAT=0: 0x44 is line 4 lane 1, sampled in the handshake cycle
        bus_b.core_req = 1'b1; bus_b.core_we = 1'b0; bus_b.core_addr = 32'h44;
        bus_b.rready = 1'b1;
        tick();
        bus_b.core_req = 1'b0;
        chk("l0_rvalid", 128'(bus_b.rvalid), 128'd1);
        chk("l0_raddr",  128'(bus_b.raddr),  128'd4);
        tick();
        bus_b.rready = 1'b0;
        chk("l0_crv",    128'(bus_b.core_rvalid), 128'd1);
        chk("l0_crdata", 128'(bus_b.core_rdata),  128'h0B0B0B01);
        chk("l0_rdrop",  128'(bus_b.rvalid),      128'd0);
        tick();

        // TIMEOUT=4 with rready held low: 4 cycles of rvalid, then error
        bus_b.core_req = 1'b1; bus_b.core_addr = 32'h40;
        tick();
        bus_b.core_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("to_rvalid", 128'(bus_b.rvalid), 128'd1);
            tick();
        end
        chk("to_rdrop",  128'(bus_b.rvalid),      128'd0);
        chk("to_crv",    128'(bus_b.core_rvalid), 128'd1);
        chk("to_cerr",   128'(bus_b.core_err),    128'd1);
        chk("to_crdata", 128'(bus_b.core_rdata),  128'd0);
        tick();
        chk("to_gnt_back", 128'(bus_b.core_gnt), 128'd1);

        // Ready arriving in the timeout cycle wins: 0x48 is line 4 lane 2
        bus_b.core_req = 1'b1; bus_b.core_addr = 32'h48;
        tick();
        bus_b.core_req = 1'b0;
        tick();
        tick();
        tick();
        bus_b.rready = 1'b1;
        chk("race_rvalid", 128'(bus_b.rvalid), 128'd1);
        tick();
        bus_b.rready = 1'b0;
        chk("race_crv",    128'(bus_b.core_rvalid), 128'd1);
        chk("race_cerr",   128'(bus_b.core_err),    128'd0);
        chk("race_crdata", 128'(bus_b.core_rdata),  128'h600D0002);
        tick();

        // Reset while in RD_WAIT aborts with no response
        bus_a.core_req = 1'b1; bus_a.core_we = 1'b0; bus_a.core_addr = 32'h0;
        bus_a.rready = 1'b1;
        tick();
        bus_a.core_req = 1'b0;
        chk("rr_rvalid", 128'(bus_a.rvalid), 128'd1);
        tick();
        chk("rr_in_wait", 128'(bus_a.rvalid), 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.rready = 1'b0;
        chk("rr_gnt",    128'(bus_a.core_gnt),    128'd1);
        chk("rr_rvalid0", 128'(bus_a.rvalid),     128'd0);
        chk("rr_crv",    128'(bus_a.core_rvalid), 128'd0);
        tick();
        chk("rr_crv_after", 128'(bus_a.core_rvalid), 128'd0);
        chk("rr_gnt_after", 128'(bus_a.core_gnt),    128'd1);
        tick();
        chk("rr_crv_after2", 128'(bus_a.core_rvalid), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
